vc_pop_arbiter: RTL and testbench

//  Drain side of the per-VC fifo16_cond buffers: selects one non-empty input FIFO per cycle,

---
 rtl/vc_pop_arbiter_pkg.sv | 10 +
 rtl/vc_pop_arbiter_rr_pick.sv | 18 +
 rtl/vc_pop_arbiter.sv | 62 ++++++
 tb/tb_vc_pop_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/vc_pop_arbiter_pkg.sv
// vc_pop_arbiter_pkg: shared defaults and FSM state encoding for the VC drain arbiter
package vc_pop_arbiter_pkg;
    localparam int DEF_BW  = 6;
    localparam int DEF_NCH = 4;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PAUSE  = 2'd2
    } state_t;
endpackage

// File: rtl/vc_pop_arbiter_rr_pick.sv
// vc_pop_arbiter_rr_pick: round-robin priority find starting just after ptr
module vc_pop_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);
    // Scan from the farthest offset down so the nearest set bit after ptr wins
    always_comb begin
        valid = |mask;
        idx   = '0;
        for (int k = N; k >= 1; k--)
            if (mask[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
    end
endmodule

// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter: pops one non-empty VC FIFO per cycle into the egress FIFO with congestion priority and pause hysteresis
module vc_pop_arbiter
    import vc_pop_arbiter_pkg::*;
#(
    parameter int BW  = DEF_BW,
    parameter int NCH = DEF_NCH,
    localparam int IW = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [NCH*BW-1:0] in_data,
    input  logic [NCH-1:0]    in_empty,
    input  logic [NCH-1:0]    in_almost_full,
    output logic [NCH-1:0]    in_pop,
    input  logic              out_full,
    input  logic              out_almost_full,
    input  logic              out_empty,
    input  logic              out_almost_empty,
    output logic              out_push,
    output logic [BW-1:0]     out_data,
    output logic [IW-1:0]     out_grant,
    output logic              paused
);
    state_t        state;
    logic [IW-1:0] rr_ptr, win;
    logic [NCH-1:0] hi, mask;
    logic          stop, resume, any_ne, pop_en, win_valid;

    assign stop   = out_almost_full | out_full;
    assign resume = out_almost_empty | out_empty;
    assign any_ne = ~&in_empty;
    assign hi     = ~in_empty & in_almost_full;
    assign mask   = |hi ? hi : ~in_empty;
    assign pop_en = (state != PAUSE) && !stop;
    assign paused = state == PAUSE;
    assign in_pop = (pop_en && win_valid) ? NCH'(1) << win : '0;

    vc_pop_arbiter_rr_pick #(.N(NCH), .IW(IW)) u_pick (
        .mask  (mask),
        .ptr   (rr_ptr),
        .valid (win_valid),
        .idx   (win)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            rr_ptr    <= IW'(NCH - 1);
            out_push  <= 1'b0;
            out_data  <= '0;
            out_grant <= '0;
        end else begin
            state    <= stop ? PAUSE : (state == PAUSE && !resume) ? PAUSE : any_ne ? ACTIVE : IDLE;
            out_push <= |in_pop;
            if (|in_pop) begin
                out_data  <= in_data[int'(win)*BW +: BW];
                out_grant <= win;
                rr_ptr    <= win;
            end
        end
    end
endmodule

// File: tb/tb_vc_pop_arbiter.sv
// tb_vc_pop_arbiter: directed and random stimulus checked against a rule-level model of the drain arbiter
module tb_vc_pop_arbiter;
    localparam int BW  = 6;
    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              reset_L;
    logic [NCH*BW-1:0] in_data;
    logic [NCH-1:0]    in_empty, in_almost_full, in_pop;
    logic              out_full, out_almost_full, out_empty, out_almost_empty;
    logic              out_push, paused;
    logic [BW-1:0]     out_data;
    logic [1:0]        out_grant;

    int n_assert = 0;
    int n_fail   = 0;

    int         m_state;
    int         m_rr;
    logic       m_push;
    logic [5:0] m_data;
    logic [1:0] m_grant;

    vc_pop_arbiter #(.BW(BW), .NCH(NCH)) dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .in_data          (in_data),
        .in_empty         (in_empty),
        .in_almost_full   (in_almost_full),
        .in_pop           (in_pop),
        .out_full         (out_full),
        .out_almost_full  (out_almost_full),
        .out_empty        (out_empty),
        .out_almost_empty (out_almost_empty),
        .out_push         (out_push),
        .out_data         (out_data),
        .out_grant        (out_grant),
        .paused           (paused)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_rr    = NCH - 1;
        m_push  = 1'b0;
        m_data  = '0;
        m_grant = '0;
    endtask

    // Starts and ends on a falling edge: drive, check, clock, advance model
    task automatic step(input logic [3:0] e, input logic [3:0] af, input logic oaf, input logic of,
                        input logic oae, input logic oe);
        logic [3:0] hi, mask, exp_pop;
        logic       stop, resume, any_ne, pop_en;
        int         w;
        in_empty         = e;
        in_almost_full   = af;
        out_almost_full  = oaf;
        out_full         = of;
        out_almost_empty = oae;
        out_empty        = oe;
        in_data          = {$urandom, $urandom};
        #1;
        stop   = oaf | of;
        resume = oae | oe;
        any_ne = (e != 4'hF);
        pop_en = (m_state != 2) && !stop;
        hi     = ~e & af;
        mask   = (hi != 0) ? hi : ~e;
        w = -1;
        for (int k = 1; k <= NCH; k++)
            if (w < 0 && mask[(m_rr + k) % NCH]) w = (m_rr + k) % NCH;
        exp_pop = (pop_en && w >= 0) ? 4'(1 << w) : 4'b0;
        check("in_pop", 32'(in_pop), 32'(exp_pop));
        check("paused", 32'(paused), 32'(m_state == 2));
        check("out_push", 32'(out_push), 32'(m_push));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_grant", 32'(out_grant), 32'(m_grant));
        @(posedge clk);
        if (exp_pop != 0) begin
            m_push  = 1'b1;
            m_data  = in_data[w*BW +: BW];
            m_grant = 2'(w);
            m_rr    = w;
        end else m_push = 1'b0;
        if (stop) m_state = 2;
        else if (m_state == 2 && !resume) m_state = 2;
        else m_state = any_ne ? 1 : 0;
        @(negedge clk);
    endtask

    initial begin
        reset_L = 1'b0;
        in_data = '0; in_empty = 4'hF; in_almost_full = 4'h0;
        out_full = 0; out_almost_full = 0; out_empty = 1; out_almost_empty = 1;
        model_reset();
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        repeat (10) step(4'hF, 4'h0, 0, 0, 0, 0);
        repeat (6) step(4'h0, 4'h0, 0, 0, 0, 0);
        repeat (4) step(4'h0, 4'b0100, 0, 0, 0, 0);
        repeat (4) step(4'h0, 4'h0, 0, 0, 0, 0);
        step(4'h0, 4'h0, 1, 0, 0, 0);
        repeat (4) step(4'h0, 4'h0, 0, 0, 0, 0);
        step(4'h0, 4'h0, 1, 0, 1, 0);
        step(4'h0, 4'h0, 0, 0, 1, 0);
        repeat (3) step(4'h0, 4'h0, 0, 0, 0, 0);
        step(4'h0, 4'h0, 0, 1, 0, 0);
        step(4'hF, 4'h0, 0, 0, 0, 1);
        repeat (3) step(4'b1101, 4'h0, 0, 0, 0, 0);
        repeat (3) step(4'hF, 4'h0, 0, 0, 0, 0);
        repeat (3) step(4'h0, 4'h0, 0, 0, 0, 0);
        @(posedge clk);
        #3 reset_L = 1'b0;
        #1;
        check("async_rst_push", 32'(out_push), 32'(0));
        check("async_rst_grant", 32'(out_grant), 32'(0));
        check("async_rst_paused", 32'(paused), 32'(0));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_L = 1'b1;
        repeat (3) step(4'h0, 4'h0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++)
            step(4'($urandom), ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0,
                 $urandom_range(9) == 0, $urandom_range(19) == 0,
                 $urandom_range(2) == 0, $urandom_range(4) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
